token_dispatcher: RTL and testbench

- Dispatch-side read engine for the token buffer's Dispatcher port (src_sel=1).
- Accepts a command naming a contiguous token range and a target expert, then issues one read per token into the token buffer.
- Realigns the read data returned TB_RD_LAT cycles later and streams the tokens to the expert datapath over a valid/ready interface.
- Read issue is credit-limited against an internal FIFO, so backpressure never drops data.

---
 rtl/tb_pkg.sv | 21 ++
 rtl/disp_ret_fifo.sv | 57 +++++
 rtl/token_dispatcher.sv | 127 ++++++++++++
 tb/tb_token_dispatcher.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tb_pkg.sv
// Shared token-buffer definitions: geometry, source-select codes and the
// dispatcher FSM state encoding.
package tb_pkg;

  localparam int ADDR_W    = 8;
  localparam int DATA_W    = 64;
  localparam int TB_RD_LAT = 3;

  localparam logic [1:0] SRC_DRAM = 2'd0;
  localparam logic [1:0] SRC_DISP = 2'd1;
  localparam logic [1:0] SRC_COL  = 2'd2;
  localparam logic [1:0] SRC_GATE = 2'd3;

  typedef logic [1:0] disp_state_t;

  localparam disp_state_t ST_IDLE  = 2'd0;
  localparam disp_state_t ST_ISSUE = 2'd1;
  localparam disp_state_t ST_DRAIN = 2'd2;
  localparam disp_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/disp_ret_fifo.sv
// Return FIFO for the dispatcher: absorbs realigned read data so the consumer
// may stall without dropping tokens. Push and pop may coincide at any occupancy.
module disp_ret_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; empty/valid gating hides stale
  // entries, and leaving it out keeps this a plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop));

endmodule

// File: rtl/token_dispatcher.sv
// Dispatcher-port read engine: issues one token-buffer read per token of a
// command, realigns the returning data and streams it to an expert.
module token_dispatcher #(
  parameter int ADDR_W     = tb_pkg::ADDR_W,
  parameter int DATA_W     = tb_pkg::DATA_W,
  parameter int TB_RD_LAT  = tb_pkg::TB_RD_LAT,
  parameter int FIFO_DEPTH = 8,
  parameter int EXP_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_cmd_valid,
  output logic              out_cmd_ready,
  input  logic [ADDR_W-1:0] in_cmd_base,
  input  logic [ADDR_W:0]   in_cmd_len,
  input  logic [EXP_W-1:0]  in_cmd_expert,
  output logic              out_tb_req,
  input  logic              in_tb_gnt,
  output logic              out_disp_req,
  output logic [ADDR_W-1:0] out_disp_addr,
  input  logic [DATA_W-1:0] in_disp_rdata,
  output logic              out_tok_valid,
  input  logic              in_tok_ready,
  output logic [DATA_W-1:0] out_tok_data,
  output logic [EXP_W-1:0]  out_tok_expert,
  output logic              out_tok_last,
  output logic              out_done,
  output logic              out_busy
);

  import tb_pkg::disp_state_t;
  import tb_pkg::ST_IDLE;
  import tb_pkg::ST_ISSUE;
  import tb_pkg::ST_DRAIN;
  import tb_pkg::ST_DONE;

  localparam int INF_W = $clog2(TB_RD_LAT + 1);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  disp_state_t          state, state_nxt;
  logic [ADDR_W-1:0]    base_q;
  logic [ADDR_W:0]      len_q, issued_q, popped_q;
  logic [EXP_W-1:0]     expert_q;
  logic [TB_RD_LAT-1:0] vld_sr, last_sr;
  logic [INF_W-1:0]     inflight;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_full, fifo_empty;
  logic [DATA_W:0]      fifo_head;
  logic                 accept, issue, issue_last, pop;

  assign inflight   = INF_W'($countones(vld_sr));
  assign accept     = (state == ST_IDLE) && in_cmd_valid;
  assign issue_last = ((issued_q + 1'b1) == len_q);
  assign pop        = !fifo_empty && in_tok_ready;

  // Credit uses this cycle's occupancy only; a same-cycle pop is not counted,
  // so the FIFO can never be asked to hold more than FIFO_DEPTH entries.
  assign issue = (state == ST_ISSUE) && in_tb_gnt && (issued_q < len_q) &&
                 ((int'(inflight) + int'(fifo_count)) < FIFO_DEPTH);

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (in_cmd_valid) state_nxt = (in_cmd_len == '0) ? ST_DONE : ST_ISSUE;
      ST_ISSUE: if (issue && issue_last) state_nxt = ST_DRAIN;
      ST_DRAIN: if ((inflight == '0) && fifo_empty && (popped_q == len_q)) state_nxt = ST_DONE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      base_q   <= '0;
      len_q    <= '0;
      expert_q <= '0;
      issued_q <= '0;
      popped_q <= '0;
      vld_sr   <= '0;
      last_sr  <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base_q   <= in_cmd_base;
        len_q    <= in_cmd_len;
        expert_q <= in_cmd_expert;
        issued_q <= '0;
        popped_q <= '0;
      end else begin
        if (issue) issued_q <= issued_q + 1'b1;
        if (pop)   popped_q <= popped_q + 1'b1;
      end
      vld_sr  <= (vld_sr << 1)  | TB_RD_LAT'(issue);
      last_sr <= (last_sr << 1) | TB_RD_LAT'(issue && issue_last);
    end
  end

  disp_ret_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_sr[TB_RD_LAT-1]),
    .wdata ({last_sr[TB_RD_LAT-1], in_disp_rdata}),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_cmd_ready  = (state == ST_IDLE);
  assign out_tb_req     = (state == ST_ISSUE) || ((state == ST_DRAIN) && (inflight != '0));
  assign out_disp_req   = issue;
  assign out_disp_addr  = issue ? (base_q + issued_q[ADDR_W-1:0]) : '0;
  assign out_tok_valid  = !fifo_empty;
  assign out_tok_data   = fifo_empty ? '0 : fifo_head[DATA_W-1:0];
  assign out_tok_last   = !fifo_empty && fifo_head[DATA_W];
  assign out_tok_expert = expert_q;
  assign out_done       = (state == ST_DONE);
  assign out_busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_token_dispatcher.sv
// Self-checking bench for token_dispatcher: a behavioural token-buffer memory
// plus per-command expectations derived from base/len/expert.
module tb_token_dispatcher;

  localparam int LAT = 3;

  logic        clk, rst_n;
  logic        in_cmd_valid, out_cmd_ready;
  logic [7:0]  in_cmd_base;
  logic [8:0]  in_cmd_len;
  logic [2:0]  in_cmd_expert;
  logic        out_tb_req, in_tb_gnt, out_disp_req;
  logic [7:0]  out_disp_addr;
  logic [63:0] in_disp_rdata;
  logic        out_tok_valid, in_tok_ready;
  logic [63:0] out_tok_data;
  logic [2:0]  out_tok_expert;
  logic        out_tok_last, out_done, out_busy;

  int vectors = 0;
  int miscompares = 0;

  token_dispatcher dut (
    .clk(clk), .rst_n(rst_n),
    .in_cmd_valid(in_cmd_valid), .out_cmd_ready(out_cmd_ready),
    .in_cmd_base(in_cmd_base), .in_cmd_len(in_cmd_len), .in_cmd_expert(in_cmd_expert),
    .out_tb_req(out_tb_req), .in_tb_gnt(in_tb_gnt),
    .out_disp_req(out_disp_req), .out_disp_addr(out_disp_addr), .in_disp_rdata(in_disp_rdata),
    .out_tok_valid(out_tok_valid), .in_tok_ready(in_tok_ready),
    .out_tok_data(out_tok_data), .out_tok_expert(out_tok_expert), .out_tok_last(out_tok_last),
    .out_done(out_done), .out_busy(out_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Token buffer model: a read strobed in cycle t returns its word in cycle t+LAT.
  logic [63:0]    tb_mem [256];
  logic [LAT-1:0] p_vld = '0;
  logic [7:0]     p_addr [LAT];

  always @(posedge clk) begin
    p_vld     <= {p_vld[LAT-2:0], out_disp_req};
    p_addr[0] <= out_disp_addr;
    for (int i = 1; i < LAT; i++) p_addr[i] <= p_addr[i-1];
  end
  assign in_disp_rdata = p_vld[LAT-1] ? tb_mem[p_addr[LAT-1]] : '0;

  function automatic logic [63:0] exp_data(input logic [7:0] base, input int i);
    logic [7:0] a;
    a = base + 8'(i);
    return tb_mem[a];
  endfunction

  // Observations of one command, filled by run_cmd and judged by each test.
  logic [7:0]  obs_addr [$];
  int          obs_issue_cyc [$];
  logic [63:0] obs_data [$];
  logic        obs_last [$];
  logic [2:0]  obs_exp [$];
  int          done_cnt, done_cyc, first_valid_cyc, max_out, hold_err, nogrant_issue;
  bit          req_seen, timed_out, accepted;

  task automatic run_cmd(input logic [7:0] base, input logic [8:0] len, input logic [2:0] expert,
                         input int ready_hold, input int gnt_off_at, input int gnt_off_len,
                         input bit rand_ready, input int budget);
    int issued, popped, post_done;
    bit pv, pr;
    logic [63:0] pd;
    logic pl;
    obs_addr.delete(); obs_issue_cyc.delete(); obs_data.delete(); obs_last.delete(); obs_exp.delete();
    done_cnt = 0; done_cyc = -1; first_valid_cyc = -1; max_out = 0; hold_err = 0;
    nogrant_issue = 0; req_seen = 0; issued = 0; popped = 0; post_done = 0;
    @(posedge clk); #1;
    in_cmd_valid = 1'b1; in_cmd_base = base; in_cmd_len = len; in_cmd_expert = expert;
    in_tb_gnt = 1'b1; in_tok_ready = (ready_hold == 0);
    @(negedge clk);
    accepted = out_cmd_ready;
    pv = out_tok_valid; pr = in_tok_ready; pd = out_tok_data; pl = out_tok_last;
    for (int c = 1; c <= budget; c++) begin
      @(posedge clk); #1;
      in_cmd_valid = 1'b0;
      in_tb_gnt    = !(c >= gnt_off_at && c < gnt_off_at + gnt_off_len);
      in_tok_ready = (c > ready_hold) && (!rand_ready || $urandom_range(0, 3) != 0);
      @(negedge clk);
      if (out_tb_req) req_seen = 1'b1;
      if (out_disp_req) begin
        obs_addr.push_back(out_disp_addr); obs_issue_cyc.push_back(c); issued++;
        if (!in_tb_gnt) nogrant_issue++;
      end
      if (out_tok_valid && first_valid_cyc < 0) first_valid_cyc = c;
      if (pv && !pr && (!out_tok_valid || out_tok_data !== pd || out_tok_last !== pl)) hold_err++;
      if (out_tok_valid && in_tok_ready) begin
        obs_data.push_back(out_tok_data); obs_last.push_back(out_tok_last);
        obs_exp.push_back(out_tok_expert); popped++;
      end
      if (issued - popped > max_out) max_out = issued - popped;
      pv = out_tok_valid; pr = in_tok_ready; pd = out_tok_data; pl = out_tok_last;
      if (out_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0) begin
        post_done++;
        if (post_done > 3) break;
      end
    end
    timed_out = (done_cyc < 0);
    in_tok_ready = 1'b1; in_tb_gnt = 1'b1;
  endtask

  task automatic test_reset();
    logic [81:0] got, want;
    want = '0; want[81] = 1'b1;
    repeat (2) @(negedge clk);
    got = {out_cmd_ready, out_tb_req, out_disp_req, out_disp_addr, out_tok_valid, out_tok_data,
           out_tok_expert, out_tok_last, out_done, out_busy};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_in: got %h want %h", got, want);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    got = {out_cmd_ready, out_tb_req, out_disp_req, out_disp_addr, out_tok_valid, out_tok_data,
           out_tok_expert, out_tok_last, out_done, out_busy};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL reset_out: got %h want %h", got, want);
    end
  endtask

  task automatic test_basic();
    run_cmd(8'h10, 9'd4, 3'd5, 0, 0, 0, 1'b0, 200);
    vectors++;
    if (!accepted || timed_out || done_cnt != 1) begin
      miscompares++;
      $display("FAIL basic_done: got acc=%0b pulses=%0d want acc=1 pulses=1", accepted, done_cnt);
    end
    vectors++;
    if (obs_data.size() != 4 || obs_addr.size() != 4) begin
      miscompares++;
      $display("FAIL basic_count: got tok=%0d rd=%0d want 4/4", obs_data.size(), obs_addr.size());
    end
    for (int i = 0; i < obs_data.size() && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== 8'(8'h10 + i) || obs_data[i] !== exp_data(8'h10, i) ||
          obs_last[i] !== (i == 3) || obs_exp[i] !== 3'd5) begin
        miscompares++;
        $display("FAIL basic_tok%0d: got a=%h d=%h l=%b e=%0d want a=%h d=%h l=%b e=5", i,
                 obs_addr[i], obs_data[i], obs_last[i], obs_exp[i], 8'(8'h10 + i),
                 exp_data(8'h10, i), (i == 3));
      end
    end
    vectors++;
    if (obs_issue_cyc.size() != 4 || obs_issue_cyc[3] - obs_issue_cyc[0] != 3 ||
        first_valid_cyc - obs_issue_cyc[0] != LAT + 1) begin
      miscompares++;
      $display("FAIL basic_timing: got first_tok_delay=%0d want %0d", first_valid_cyc - obs_issue_cyc[0], LAT + 1);
    end
  endtask

  task automatic test_wrap();
    run_cmd(8'hFE, 9'd4, 3'd2, 0, 0, 0, 1'b0, 200);
    vectors++;
    if (timed_out || done_cnt != 1 || obs_data.size() != 4 || obs_addr.size() != 4) begin
      miscompares++;
      $display("FAIL wrap_count: got tok=%0d rd=%0d pulses=%0d want 4/4/1", obs_data.size(), obs_addr.size(), done_cnt);
    end
    for (int i = 0; i < obs_data.size() && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== 8'(8'hFE + i) || obs_data[i] !== exp_data(8'hFE, i) || obs_last[i] !== (i == 3)) begin
        miscompares++;
        $display("FAIL wrap_tok%0d: got a=%h d=%h l=%b want a=%h d=%h l=%b", i, obs_addr[i], obs_data[i],
                 obs_last[i], 8'(8'hFE + i), exp_data(8'hFE, i), (i == 3));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] base;
    base = 8'($urandom);
    run_cmd(base, 9'd20, 3'd3, 30, 0, 0, 1'b0, 400);
    vectors++;
    if (max_out != 8 || hold_err != 0) begin
      miscompares++; $display("FAIL bp_credit: got outstanding=%0d hold_err=%0d want 8/0", max_out, hold_err);
    end
    vectors++;
    if (timed_out || done_cnt != 1 || obs_data.size() != 20 || obs_addr.size() != 20) begin
      miscompares++;
      $display("FAIL bp_count: got tok=%0d rd=%0d pulses=%0d want 20/20/1", obs_data.size(), obs_addr.size(), done_cnt);
    end
    for (int i = 0; i < obs_data.size() && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== 8'(base + i) || obs_data[i] !== exp_data(base, i) ||
          obs_last[i] !== (i == 19) || obs_exp[i] !== 3'd3) begin
        miscompares++;
        $display("FAIL bp_tok%0d: got a=%h d=%h l=%b e=%0d want a=%h d=%h l=%b e=3", i, obs_addr[i],
                 obs_data[i], obs_last[i], obs_exp[i], 8'(base + i), exp_data(base, i), (i == 19));
      end
    end
  endtask

  task automatic test_grant_toggle();
    logic [7:0] base;
    base = 8'($urandom);
    run_cmd(base, 9'd16, 3'd1, 0, 4, 5, 1'b0, 300);
    vectors++;
    if (nogrant_issue != 0 || obs_issue_cyc.size() != 16 ||
        obs_issue_cyc[15] - obs_issue_cyc[0] != 15 + 5) begin
      miscompares++;
      $display("FAIL gnt_pause: got ungranted=%0d reads=%0d want 0/16 with a 5-cycle gap", nogrant_issue, obs_issue_cyc.size());
    end
    vectors++;
    if (timed_out || done_cnt != 1 || obs_data.size() != 16) begin
      miscompares++; $display("FAIL gnt_count: got tok=%0d pulses=%0d want 16/1", obs_data.size(), done_cnt);
    end
    for (int i = 0; i < obs_data.size() && i < obs_addr.size(); i++) begin
      vectors++;
      if (obs_addr[i] !== 8'(base + i) || obs_data[i] !== exp_data(base, i) || obs_last[i] !== (i == 15)) begin
        miscompares++;
        $display("FAIL gnt_tok%0d: got a=%h d=%h l=%b want a=%h d=%h l=%b", i, obs_addr[i], obs_data[i],
                 obs_last[i], 8'(base + i), exp_data(base, i), (i == 15));
      end
    end
  endtask

  task automatic test_zero_len();
    run_cmd(8'h40, 9'd0, 3'd7, 0, 0, 0, 1'b0, 20);
    vectors++;
    if (timed_out || done_cnt != 1 || done_cyc > 2) begin
      miscompares++; $display("FAIL zero_done: got pulses=%0d at cycle %0d want 1 within 2", done_cnt, done_cyc);
    end
    vectors++;
    if (req_seen || obs_addr.size() != 0 || obs_data.size() != 0) begin
      miscompares++;
      $display("FAIL zero_quiet: got req=%0b rd=%0d tok=%0d want 0/0/0", req_seen, obs_addr.size(), obs_data.size());
    end
  endtask

  task automatic test_full_len();
    logic [7:0] base;
    int bad;
    base = 8'($urandom);
    bad = 0;
    run_cmd(base, 9'd256, 3'd4, 0, 0, 0, 1'b1, 3000);
    vectors++;
    if (timed_out || done_cnt != 1 || obs_data.size() != 256 || obs_addr.size() != 256 || hold_err != 0) begin
      miscompares++;
      $display("FAIL full_count: got tok=%0d rd=%0d pulses=%0d hold_err=%0d want 256/256/1/0",
               obs_data.size(), obs_addr.size(), done_cnt, hold_err);
    end
    for (int i = 0; i < obs_data.size() && i < obs_addr.size(); i++) begin
      if (obs_addr[i] !== 8'(base + i) || obs_data[i] !== exp_data(base, i) || obs_last[i] !== (i == 255)) begin
        if (bad == 0) $display("FAIL full_tok%0d: got a=%h d=%h want a=%h d=%h", i, obs_addr[i], obs_data[i],
                               8'(base + i), exp_data(base, i));
        bad++;
      end
    end
    vectors++;
    if (bad != 0) begin
      miscompares++; $display("FAIL full_stream: got %0d bad tokens want 0", bad);
    end
  endtask

  task automatic test_reset_mid_drain();
    logic [81:0] got, want;
    logic [7:0] base;
    want = '0; want[81] = 1'b1;
    @(posedge clk); #1;
    in_cmd_valid = 1'b1; in_cmd_base = 8'($urandom); in_cmd_len = 9'd10; in_cmd_expert = 3'd6;
    in_tok_ready = 1'b0; in_tb_gnt = 1'b1;
    @(posedge clk); #1 in_cmd_valid = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    vectors++;
    if (out_tok_valid !== 1'b1 || out_busy !== 1'b1) begin
      miscompares++; $display("FAIL rst_mid_pre: got valid=%b busy=%b want 1/1", out_tok_valid, out_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    got = {out_cmd_ready, out_tb_req, out_disp_req, out_disp_addr, out_tok_valid, out_tok_data,
           out_tok_expert, out_tok_last, out_done, out_busy};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL rst_mid_async: got %h want %h", got, want);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1; in_tok_ready = 1'b1;
    @(negedge clk);
    got = {out_cmd_ready, out_tb_req, out_disp_req, out_disp_addr, out_tok_valid, out_tok_data,
           out_tok_expert, out_tok_last, out_done, out_busy};
    vectors++;
    if (got !== want) begin
      miscompares++; $display("FAIL rst_mid_release: got %h want %h", got, want);
    end
    base = 8'($urandom);
    run_cmd(base, 9'd5, 3'd2, 0, 0, 0, 1'b0, 200);
    vectors++;
    if (timed_out || done_cnt != 1 || obs_data.size() != 5) begin
      miscompares++; $display("FAIL rst_mid_next: got tok=%0d pulses=%0d want 5/1", obs_data.size(), done_cnt);
    end
    for (int i = 0; i < obs_data.size(); i++) begin
      vectors++;
      if (obs_data[i] !== exp_data(base, i) || obs_last[i] !== (i == 4) || obs_exp[i] !== 3'd2) begin
        miscompares++;
        $display("FAIL rst_mid_tok%0d: got d=%h l=%b e=%0d want d=%h l=%b e=2", i, obs_data[i], obs_last[i],
                 obs_exp[i], exp_data(base, i), (i == 4));
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] base;
    logic [8:0] len;
    logic [2:0] expert;
    for (int n = 0; n < 6; n++) begin
      base   = 8'($urandom);
      len    = 9'($urandom_range(1, 40));
      expert = 3'($urandom);
      run_cmd(base, len, expert, $urandom_range(0, 12), $urandom_range(1, 10), $urandom_range(0, 6), 1'b1, 800);
      vectors++;
      if (timed_out || done_cnt != 1 || obs_data.size() != int'(len) || obs_addr.size() != int'(len) ||
          nogrant_issue != 0 || max_out > 8 || hold_err != 0) begin
        miscompares++;
        $display("FAIL rand%0d_ctl: got tok=%0d rd=%0d pulses=%0d ungranted=%0d out=%0d hold=%0d want len=%0d",
                 n, obs_data.size(), obs_addr.size(), done_cnt, nogrant_issue, max_out, hold_err, len);
      end
      for (int i = 0; i < obs_data.size() && i < obs_addr.size(); i++) begin
        vectors++;
        if (obs_addr[i] !== 8'(base + i) || obs_data[i] !== exp_data(base, i) ||
            obs_last[i] !== (i == int'(len) - 1) || obs_exp[i] !== expert) begin
          miscompares++;
          $display("FAIL rand%0d_tok%0d: got a=%h d=%h l=%b e=%0d want a=%h d=%h e=%0d", n, i, obs_addr[i],
                   obs_data[i], obs_last[i], obs_exp[i], 8'(base + i), exp_data(base, i), expert);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) tb_mem[i] = {$urandom, $urandom};
    rst_n = 1'b0; in_cmd_valid = 1'b0; in_cmd_base = '0; in_cmd_len = '0; in_cmd_expert = '0;
    in_tb_gnt = 1'b0; in_tok_ready = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_grant_toggle();
    test_zero_len();
    test_full_len();
    test_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion within 1 ms want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
